vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Sequencer that runs the vending machine's dispense phase once a purchase has been paid for. It accepts one vend request, holding a product code and the change due. It drives the product motor until the product has dropped, then pays change through the coin hopper one coin at a time with a valid/ack handshake. It sits between the payment FSM and the motor/hopper drivers and owns both actuators exclusively.

## Interface
- `DISPENSE_CYCLES`, default 8: motor-on duration in cycles, used when no drop sensor is compiled in; minimum 1.
- `DROP_TIMEOUT`, default 64: maximum motor-on cycles waiting for the drop sensor before a fault.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `req_valid` input, 1 bit: vend request present.
- `req_ready` output, 1 bit: controller can accept a request.
- `req_product` input, 4 bits: {food_categ, select} product code.
- `req_change` input, 6 bits: change due, in rupees (0–63).
- `motor_en` output, 1 bit: product motor drive.
- `motor_sel` output, 4 bits: product code of the motor being driven.
- `drop_sensor` input, 1 bit: product-dropped pulse. Present only with `VEND_DROP_SENSOR_EN`.
- `hop_valid` output, 1 bit: coin payout request.
- `hop_coin` output, 2 bits: coin code. 01 = 5, 10 = 10, 11 = 20; 00 is never issued.
- `hop_ack` input, 1 bit: hopper has ejected the presented coin.
- `done` output, 1 bit: one-cycle pulse when the vend completes.
- `short_change` output, 1 bit: valid with `done`; residue below 5 was not payable.
- `fault` output, 1 bit: level, set on drop timeout.
- `fault_clear` input, 1 bit: leave the fault state.
- `busy` output, 1 bit: high whenever the controller is not in IDLE.

## Operation
- States: IDLE, DISPENSE, PAYOUT, DONE, FAULT.
- IDLE
  - `req_ready` = 1.
  - On `req_valid` & `req_ready`: latch product and change into `remaining`, then go to DISPENSE.
- DISPENSE
  - `motor_en` = 1 and `motor_sel` = latched product.
  - The exit condition is set by the configuration macro (see Configuration).
  - Exit to PAYOUT if `remaining` ≥ 5; otherwise exit to DONE.
- PAYOUT
  - `hop_valid` = 1.
  - `hop_coin` is chosen greedily: 20 if `remaining` ≥ 20, else 10 if ≥ 10, else 5.
  - On `hop_ack`, subtract the coin value from `remaining`.
  - If the new `remaining` is below 5, go to DONE; otherwise stay in PAYOUT and present the next coin.
- DONE
  - `done` = 1 for exactly one cycle.
  - `short_change` = (`remaining` != 0).
  - Next state is IDLE.
- FAULT
  - `fault` = 1 and motor off.
  - `remaining` is held.
  - `fault_clear` returns to IDLE; change is not paid.
- Arithmetic: `remaining` is 6-bit unsigned. Subtraction never underflows because the coin choice is bounded by `remaining`.
- `hop_ack` is ignored when `hop_valid` = 0.
- `req_valid` is ignored outside IDLE.
- `req_change` of 1–4 produces no payout; the vend goes straight to DONE with `short_change` = 1.

## Timing
- Reset values: state IDLE, `remaining` 0, `motor_en` 0, `motor_sel` 0, `hop_valid` 0, `hop_coin` 00, `done` 0, `short_change` 0, `fault` 0, `busy` 0, `req_ready` 1.
- Reset mid-operation stops the motor and hopper request on the next edge. No payout resumes.
- The cycle after request acceptance, `motor_en` = 1.
- All outputs are registered.
- `hop_coin` is stable while `hop_valid` is high and not yet acked.
- After an ack, the next coin is presented the following cycle; `hop_valid` may stay high continuously between coins.
- The hopper may hold off `hop_ack` indefinitely. There is no hopper timeout.
- Minimum vend with zero change takes DISPENSE_CYCLES + 2 cycles from acceptance to the `done` pulse; the next request can be accepted the cycle after `done`.
- If `fault_clear` and reset are asserted in the same cycle, reset wins.

## Configuration
- `VEND_DROP_SENSOR_EN` defined:
  - The `drop_sensor` port exists.
  - DISPENSE exits when `drop_sensor` = 1.
  - If `drop_sensor` has not arrived after `DROP_TIMEOUT` motor cycles, go to FAULT.
  - A sensor pulse in the same cycle as the timeout counts as success.
- `VEND_DROP_SENSOR_EN` undefined:
  - The `drop_sensor` port is absent.
  - DISPENSE lasts exactly `DISPENSE_CYCLES` cycles.
  - FAULT is unreachable and `fault` is tied to 0.

## Structure
- Shared package `vend_pkg` holds:
  - coin codes ZERO/FIVE/TEN/TWENTY and their rupee values;
  - the controller state encoding;
  - the 6-bit money width constant.
- Sub-module `vend_change_sel`: combinational greedy coin selector, mapping `remaining` to the coin code and coin value. It is reusable by the payment FSM for cancel refunds.

## Test plan
- Product 4'b0110, change 35, hopper acks each coin one cycle after presentation:
  - coins presented 20, 10, 5;
  - `done` with `short_change` = 0;
  - motor high for 8 cycles (sensor macro undefined).
- Change 0:
  - no `hop_valid` ever;
  - `done` exactly 10 cycles after acceptance.
- Change 7:
  - a single 5 coin is paid;
  - `done` with `short_change` = 1.
- With `VEND_DROP_SENSOR_EN` and no sensor pulse:
  - `fault` = 1 after 64 motor cycles;
  - no payout;
  - `fault_clear` gives `req_ready` = 1 the next cycle.
- Reset asserted during PAYOUT with `remaining` = 30:
  - next cycle `hop_valid` = 0 and `busy` = 0;
  - `remaining` is cleared.
- `req_valid` held high during a vend:
  - the second request is accepted only the cycle after `done`;
  - `hop_ack` pulses while `hop_valid` = 0 do not change `remaining`.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense path: coin codes and values,
// controller state encoding, and the money width.
package vend_pkg;

  localparam int MONEY_W = 6;

  typedef logic [MONEY_W-1:0] money_t;

  typedef enum logic [1:0] {
    COIN_ZERO   = 2'b00,
    COIN_FIVE   = 2'b01,
    COIN_TEN    = 2'b10,
    COIN_TWENTY = 2'b11
  } coin_e;

  localparam money_t VAL_ZERO   = money_t'(0);
  localparam money_t VAL_FIVE   = money_t'(5);
  localparam money_t VAL_TEN    = money_t'(10);
  localparam money_t VAL_TWENTY = money_t'(20);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPENSE = 3'd1,
    ST_PAYOUT   = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Request, motor, hopper and status signals of the dispense controller.
// drop_sensor exists only when VEND_DROP_SENSOR_EN is defined.
interface vend_dispense_ctrl_if;
  import vend_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_product;
  money_t     req_change;
  logic       motor_en;
  logic [3:0] motor_sel;
`ifdef VEND_DROP_SENSOR_EN
  logic       drop_sensor;
`endif
  logic       hop_valid;
  logic [1:0] hop_coin;
  logic       hop_ack;
  logic       done;
  logic       short_change;
  logic       fault;
  logic       fault_clear;
  logic       busy;

  modport master (
    output req_ready, motor_en, motor_sel, hop_valid, hop_coin,
           done, short_change, fault, busy,
    input  req_valid, req_product, req_change, hop_ack, fault_clear
`ifdef VEND_DROP_SENSOR_EN
         , drop_sensor
`endif
  );

  modport slave (
    input  req_ready, motor_en, motor_sel, hop_valid, hop_coin,
           done, short_change, fault, busy,
    output req_valid, req_product, req_change, hop_ack, fault_clear
`ifdef VEND_DROP_SENSOR_EN
         , drop_sensor
`endif
  );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy coin selector: largest coin not exceeding the amount, or nothing
// when the amount is below the smallest coin.
module vend_change_sel
  import vend_pkg::*;
(
  input  money_t remaining,
  output coin_e  coin,
  output money_t value
);

  always_comb begin
    coin  = COIN_ZERO;
    value = VAL_ZERO;
    if (remaining >= VAL_TWENTY) begin
      coin  = COIN_TWENTY;
      value = VAL_TWENTY;
    end else if (remaining >= VAL_TEN) begin
      coin  = COIN_TEN;
      value = VAL_TEN;
    end else if (remaining >= VAL_FIVE) begin
      coin  = COIN_FIVE;
      value = VAL_FIVE;
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense-phase sequencer: runs the product motor, then pays change coin by
// coin through the hopper. Define VEND_DROP_SENSOR_EN to end motoring on a drop sensor.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 8,
  parameter int DROP_TIMEOUT    = 64
) (
  input logic clk,
  input logic reset,
  vend_dispense_ctrl_if.master bus
);

  localparam int CNT_MAX = (DISPENSE_CYCLES > DROP_TIMEOUT) ? DISPENSE_CYCLES : DROP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef VEND_DROP_SENSOR_EN
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_TIMEOUT - 1);
`else
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
`endif

  state_e           state_q, state_n;
  money_t           remaining, rem_n;
  logic [3:0]       product, prod_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             disp_exit;

  logic             req_ready_q, busy_q, motor_en_q, hop_valid_q, done_q, short_q;
  logic [3:0]       motor_sel_q;
  coin_e            hop_coin_q, next_coin;
  money_t           hop_value_q, next_value;

  // Selector looks at the amount that will be owed next cycle, so the coin is
  // registered together with the state that presents it.
  vend_change_sel u_sel (
    .remaining (rem_n),
    .coin      (next_coin),
    .value     (next_value)
  );

  always_comb begin
    state_n   = state_q;
    rem_n     = remaining;
    prod_n    = product;
    cnt_n     = cnt_q;
    disp_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_n = ST_DISPENSE;
          prod_n  = bus.req_product;
          rem_n   = bus.req_change;
          cnt_n   = '0;
        end
      end
      ST_DISPENSE: begin
`ifdef VEND_DROP_SENSOR_EN
        if (bus.drop_sensor)          disp_exit = 1'b1;
        else if (cnt_q == DROP_LAST)  state_n   = ST_FAULT;
        else                          cnt_n     = cnt_q + CNT_W'(1);
`else
        if (cnt_q == DISP_LAST) disp_exit = 1'b1;
        else                    cnt_n     = cnt_q + CNT_W'(1);
`endif
        if (disp_exit) state_n = (remaining >= VAL_FIVE) ? ST_PAYOUT : ST_DONE;
      end
      ST_PAYOUT: begin
        // hop_valid is high for the whole of PAYOUT, so any ack here is genuine.
        if (bus.hop_ack) begin
          rem_n = remaining - hop_value_q;
          if (rem_n < VAL_FIVE) state_n = ST_DONE;
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_FAULT: if (bus.fault_clear) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining   <= VAL_ZERO;
      product     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      motor_en_q  <= 1'b0;
      motor_sel_q <= '0;
      hop_valid_q <= 1'b0;
      hop_coin_q  <= COIN_ZERO;
      hop_value_q <= VAL_ZERO;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_n;
      remaining   <= rem_n;
      product     <= prod_n;
      cnt_q       <= cnt_n;
      req_ready_q <= (state_n == ST_IDLE);
      busy_q      <= (state_n != ST_IDLE);
      motor_en_q  <= (state_n == ST_DISPENSE);
      motor_sel_q <= (state_n == ST_DISPENSE) ? prod_n : 4'd0;
      hop_valid_q <= (state_n == ST_PAYOUT);
      hop_coin_q  <= (state_n == ST_PAYOUT) ? next_coin : COIN_ZERO;
      hop_value_q <= (state_n == ST_PAYOUT) ? next_value : VAL_ZERO;
      done_q      <= (state_n == ST_DONE);
      short_q     <= (state_n == ST_DONE) && (rem_n != VAL_ZERO);
    end
  end

`ifdef VEND_DROP_SENSOR_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= (state_n == ST_FAULT);
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.req_ready    = req_ready_q;
  assign bus.busy         = busy_q;
  assign bus.motor_en     = motor_en_q;
  assign bus.motor_sel    = motor_sel_q;
  assign bus.hop_valid    = hop_valid_q;
  assign bus.hop_coin     = hop_coin_q;
  assign bus.done         = done_q;
  assign bus.short_change = short_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed vector table, random
// vends against an arithmetic change model, and reset/hold/fault sequences.
module tb_vend_dispense_ctrl;

  localparam int DISP    = 8;
  localparam int DROP_TO = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vend_dispense_ctrl_if bus ();

  vend_dispense_ctrl #(
    .DISPENSE_CYCLES (DISP),
    .DROP_TIMEOUT    (DROP_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent vend
  int     r_accept_waits, r_motor, r_total, r_delay_sum, r_ncoins;
  longint r_sig;
  bit     r_short, r_sel_bad, r_unstable, r_done_seen;

  typedef struct {
    logic [3:0] prod;
    logic [5:0] chg;
    int         dly;
    int         n20;
    int         n10;
    int         n5;
    bit         short_c;
  } vec_t;

  vec_t vecs [9];

`ifdef VEND_DROP_SENSOR_EN
  // Stand-in for the drop sensor: the product drops in the DISP-th motor cycle.
  bit suppress_drop = 1'b0;
  int motor_run     = 0;
  initial begin
    bus.drop_sensor = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.motor_en) motor_run++;
      else              motor_run = 0;
      bus.drop_sensor = !suppress_drop && bus.motor_en && (motor_run == DISP);
    end
  end
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint sig_from_counts(input int n20, input int n10, input int n5);
    longint s = 0;
    for (int k = 0; k < n20; k++) s = (s << 2) | 3;
    for (int k = 0; k < n10; k++) s = (s << 2) | 2;
    for (int k = 0; k < n5;  k++) s = (s << 2) | 1;
    return s * 16 + longint'(n20 + n10 + n5);
  endfunction

  // Runs one vend: offer the request, answer the hopper with per-coin delays
  // drawn from [dmin,dmax], and record what the controller did.
  task automatic applyStimulus(input logic [3:0] prod, input logic [5:0] chg,
                               input int dmin, input int dmax, input bit hold,
                               input logic [3:0] nprod, input logic [5:0] nchg,
                               input bit spurious);
    bit         pre, accepted, pending;
    logic [1:0] cur;
    int         wl;
    r_motor = 0; r_total = 0; r_delay_sum = 0; r_ncoins = 0; r_sig = 0;
    r_short = 0; r_sel_bad = 0; r_unstable = 0; r_done_seen = 0;
    bus.req_product = prod;
    bus.req_change  = chg;
    bus.req_valid   = 1'b1;
    accepted = 1'b0;
    r_accept_waits = 0;
    while (!accepted && r_accept_waits < 50) begin
      pre = bus.req_ready;
      step();
      r_accept_waits++;
      accepted = pre;
    end
    if (hold) begin
      bus.req_product = nprod;
      bus.req_change  = nchg;
    end else begin
      bus.req_valid = 1'b0;
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    r_total = 1;
    pending = 1'b0;
    wl      = 0;
    cur     = 2'b00;
    for (int cyc = 0; cyc < 600 && !r_done_seen; cyc++) begin
      r_total++;
      if (bus.hop_ack) begin
        bus.hop_ack = 1'b0;
        pending     = 1'b0;
      end
      if (bus.motor_en) begin
        r_motor++;
        if (bus.motor_sel !== prod) r_sel_bad = 1'b1;
      end
      if (bus.hop_valid) begin
        if (!pending) begin
          pending = 1'b1;
          cur     = bus.hop_coin;
          wl      = $urandom_range(dmax, dmin);
          r_delay_sum += wl;
        end else if (bus.hop_coin !== cur) begin
          r_unstable = 1'b1;
        end
        if (wl == 0) begin
          bus.hop_ack = 1'b1;
          r_sig = (r_sig << 2) | longint'(cur);
          r_ncoins++;
        end else begin
          wl--;
        end
      end else if (spurious) begin
        bus.hop_ack = 1'($urandom_range(1, 0));
      end
      if (bus.done) begin
        r_done_seen = 1'b1;
        r_short     = bus.short_change;
      end else begin
        step();
      end
    end
    bus.hop_ack = 1'b0;
    if (r_done_seen) begin
      step();
      checkOutput("done_width", bus.done, 0);
      checkOutput("idle_after_done", {bus.busy, bus.req_ready}, 2'b01);
    end
  endtask

  task automatic checkVend(input string tag, input longint exp_sig, input bit exp_short,
                           input int exp_ncoins);
    checkOutput({tag, ".done_seen"},    r_done_seen, 1);
    checkOutput({tag, ".motor_cycles"}, r_motor, DISP);
    checkOutput({tag, ".motor_sel"},    r_sel_bad, 0);
    checkOutput({tag, ".coins"},        r_sig * 16 + longint'(r_ncoins), exp_sig);
    checkOutput({tag, ".coin_stable"},  r_unstable, 0);
    checkOutput({tag, ".short"},        r_short, exp_short);
    checkOutput({tag, ".latency"},      r_total, DISP + 2 + exp_ncoins + r_delay_sum);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] p;
    logic [5:0] c;
    int         dm, n20, n10, n5, waits, motor;
    bit         sp, hv_seen;

    vecs[0] = '{4'b0110, 6'd35, 1, 1, 1, 1, 1'b0};
    vecs[1] = '{4'b0011, 6'd0,  1, 0, 0, 0, 1'b0};
    vecs[2] = '{4'b1001, 6'd7,  1, 0, 0, 1, 1'b1};
    vecs[3] = '{4'b1111, 6'd63, 0, 3, 0, 0, 1'b1};
    vecs[4] = '{4'b0001, 6'd4,  2, 0, 0, 0, 1'b1};
    vecs[5] = '{4'b0100, 6'd5,  3, 0, 0, 1, 1'b0};
    vecs[6] = '{4'b1010, 6'd45, 1, 2, 0, 1, 1'b0};
    vecs[7] = '{4'b0111, 6'd19, 0, 0, 1, 1, 1'b1};
    vecs[8] = '{4'b1100, 6'd30, 2, 1, 1, 0, 1'b0};

    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_product = 4'd0;
    bus.req_change  = 6'd0;
    bus.hop_ack     = 1'b0;
    bus.fault_clear = 1'b0;
    step();
    step();
    checkOutput("rst.req_ready",    bus.req_ready, 1);
    checkOutput("rst.busy",         bus.busy, 0);
    checkOutput("rst.motor_en",     bus.motor_en, 0);
    checkOutput("rst.motor_sel",    bus.motor_sel, 0);
    checkOutput("rst.hop_valid",    bus.hop_valid, 0);
    checkOutput("rst.hop_coin",     bus.hop_coin, 0);
    checkOutput("rst.done",         bus.done, 0);
    checkOutput("rst.short_change", bus.short_change, 0);
    checkOutput("rst.fault",        bus.fault, 0);
    reset = 1'b0;
    step();

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].prod, vecs[i].chg, vecs[i].dly, vecs[i].dly, 1'b0, 4'd0, 6'd0, 1'b0);
      checkVend($sformatf("vec%0d", i), sig_from_counts(vecs[i].n20, vecs[i].n10, vecs[i].n5),
                vecs[i].short_c, vecs[i].n20 + vecs[i].n10 + vecs[i].n5);
    end

    $display("[TB] request held through a vend, spurious acks outside payout");
    applyStimulus(4'h5, 6'd15, 1, 1, 1'b1, 4'hA, 6'd25, 1'b1);
    checkVend("hold1", sig_from_counts(0, 1, 1), 1'b0, 2);
    applyStimulus(4'hA, 6'd25, 0, 2, 1'b0, 4'd0, 6'd0, 1'b0);
    checkOutput("hold.accept_next_cycle", r_accept_waits, 1);
    checkVend("hold2", sig_from_counts(1, 0, 1), 1'b0, 2);

    $display("[TB] random vends against change model");
    for (int i = 0; i < 20; i++) begin
      p   = 4'($urandom);
      c   = 6'($urandom_range(63, 0));
      dm  = $urandom_range(3, 0);
      sp  = 1'($urandom_range(1, 0));
      n20 = c / 20;
      n10 = (c % 20) / 10;
      n5  = (c % 10) / 5;
      applyStimulus(p, c, 0, dm, 1'b0, 4'd0, 6'd0, sp);
      checkVend($sformatf("rnd%0d", i), sig_from_counts(n20, n10, n5), (c % 5) != 0,
                n20 + n10 + n5);
    end

    $display("[TB] reset during payout");
    bus.req_product = 4'h2;
    bus.req_change  = 6'd30;
    bus.req_valid   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    waits = 0;
    while (!bus.hop_valid && waits < 40) begin
      step();
      waits++;
    end
    checkOutput("rstpay.reached_payout", bus.hop_valid, 1);
    checkOutput("rstpay.first_coin",     bus.hop_coin, 2'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rstpay.hop_valid", bus.hop_valid, 0);
    checkOutput("rstpay.busy",      bus.busy, 0);
    checkOutput("rstpay.motor_en",  bus.motor_en, 0);
    checkOutput("rstpay.req_ready", bus.req_ready, 1);
    checkOutput("rstpay.remaining", dut.remaining, 0);
    step();
    step();
    checkOutput("rstpay.no_resume", {bus.hop_valid, bus.busy}, 2'b00);

`ifdef VEND_DROP_SENSOR_EN
    $display("[TB] drop timeout");
    suppress_drop   = 1'b1;
    bus.req_product = 4'h3;
    bus.req_change  = 6'd25;
    bus.req_valid   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    motor   = 0;
    hv_seen = 1'b0;
    waits   = 0;
    while (!bus.fault && waits < 200) begin
      if (bus.motor_en)  motor++;
      if (bus.hop_valid) hv_seen = 1'b1;
      step();
      waits++;
    end
    checkOutput("fault.raised",       bus.fault, 1);
    checkOutput("fault.motor_cycles", motor, DROP_TO);
    checkOutput("fault.no_payout",    hv_seen, 0);
    checkOutput("fault.motor_off",    bus.motor_en, 0);
    step();
    checkOutput("fault.level", {bus.fault, bus.hop_valid}, 2'b10);
    bus.fault_clear = 1'b1;
    step();
    bus.fault_clear = 1'b0;
    checkOutput("fault.clear_ready", bus.req_ready, 1);
    checkOutput("fault.clear_fault", bus.fault, 0);
    checkOutput("fault.clear_busy",  bus.busy, 0);
    suppress_drop = 1'b0;
`else
    hv_seen = 1'b0;
    motor   = 0;
    if (hv_seen) motor = 1;
`endif

    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
